// File: rtl/gray_dec_pkg.sv
// Shared types and default parameters for the gray-code receive tracker.
// Imported by gray2bin and gray_decode_tracker.
package gray_dec_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } gdt_state_t;

    localparam int GDT_WIDTH     = 8;
    localparam int GDT_ERR_LIMIT = 3;
    localparam int GDT_CNT_W     = 8;

endpackage

// File: rtl/gray2bin.sv
// Purely combinational gray-to-binary decoder, WIDTH-parameterised.
// Each binary bit is the XOR of the gray bit and every gray bit above it.
module gray2bin
    import gray_dec_pkg::*;
#(
    parameter int WIDTH = GDT_WIDTH
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    always_comb begin
        bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/gray_decode_tracker.sv
// Gray-code receive tracker: captures, decodes and classifies position moves.
// Optional input synchronizer is enabled by defining GRAY_DEC_SYNC_EN.
module gray_decode_tracker
    import gray_dec_pkg::*;
#(
    parameter int WIDTH     = GDT_WIDTH,
    parameter int ERR_LIMIT = GDT_ERR_LIMIT,
    parameter int CNT_W     = GDT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             sample_en,
    input  logic             err_clr,
    output logic [WIDTH-1:0] bin_out,
    output logic             valid,
    output logic             step_up,
    output logic             step_down,
    output logic             jump_err,
    output logic [CNT_W-1:0] err_count,
    output logic             fault
);

    localparam int               CONS_W   = $clog2(ERR_LIMIT + 1);
    localparam logic [CONS_W-1:0] CONS_ONE = CONS_W'(1);
    localparam logic [CONS_W-1:0] LIMIT    = CONS_W'(ERR_LIMIT);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [WIDTH-1:0]  BIN_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0]  BIN_ONES = '1;

    logic [WIDTH-1:0] cap_src;

`ifdef GRAY_DEC_SYNC_EN
    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = gray_in;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign cap_src = sync2_q;
`else
    assign cap_src = gray_in;
`endif

    // Capture stage: g_q holds the sampled code, pend_q marks it as new.
    logic [WIDTH-1:0] g_q, g_d;
    logic             pend_q, pend_d;

    always_comb begin
        g_d    = sample_en ? cap_src : g_q;
        pend_d = sample_en;
    end

    logic [WIDTH-1:0] new_bin;
    logic [WIDTH-1:0] diff;
    logic             is_up, is_down, is_jump;

    gray2bin #(.WIDTH(WIDTH)) u_gray2bin (
        .gray (g_q),
        .bin  (new_bin)
    );

    // bin_out_q always holds the previous sample, so it doubles as prev_bin.
    logic [WIDTH-1:0] bin_out_q, bin_out_d;

    always_comb begin
        diff    = new_bin - bin_out_q;
        is_up   = (diff == BIN_ONE);
        is_down = (diff == BIN_ONES);
        is_jump = (diff != '0) && !is_up && !is_down;
    end

    gdt_state_t       state_q, state_d;
    logic [CONS_W-1:0] consec_q, consec_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            consec_q <= '0;
        end else begin
            state_q  <= state_d;
            consec_q <= consec_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        consec_d = consec_q;
        case (state_q)
            IDLE: begin
                if (pend_q) state_d = TRACK;
            end
            TRACK: begin
                if (pend_q) begin
                    if (is_jump) begin
                        consec_d = consec_q + CONS_ONE;
                        if (consec_d == LIMIT) state_d = FAULT;
                    end else begin
                        consec_d = '0;
                    end
                end
            end
            FAULT: ;
            default: state_d = IDLE;
        endcase
        // err_clr overrides any transition decided above, including FAULT entry.
        if (err_clr && (state_q != IDLE)) begin
            state_d  = TRACK;
            consec_d = '0;
        end
    end

    always_comb begin
        fault = (state_q == FAULT);
    end

    logic             valid_q, valid_d;
    logic             step_up_q, step_up_d;
    logic             step_down_q, step_down_d;
    logic             jump_err_q, jump_err_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;

    // NOTE: every variable gets a default before any branch, so no latch can be inferred.
    always_comb begin
        bin_out_d   = bin_out_q;
        valid_d     = 1'b0;
        step_up_d   = 1'b0;
        step_down_d = 1'b0;
        jump_err_d  = 1'b0;
        err_count_d = err_count_q;
        if (pend_q) begin
            bin_out_d = new_bin;
            valid_d   = 1'b1;
            if (state_q != IDLE) begin
                step_up_d   = is_up   && (state_q != FAULT);
                step_down_d = is_down && (state_q != FAULT);
                jump_err_d  = is_jump;
            end
        end
        if (jump_err_d && (err_count_q != CNT_MAX)) err_count_d = err_count_q + CNT_ONE;
        if (err_clr) err_count_d = '0;
    end

    // NOTE: sequential state uses non-blocking assignments and an asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g_q         <= '0;
            pend_q      <= 1'b0;
            bin_out_q   <= '0;
            valid_q     <= 1'b0;
            step_up_q   <= 1'b0;
            step_down_q <= 1'b0;
            jump_err_q  <= 1'b0;
            err_count_q <= '0;
        end else begin
            g_q         <= g_d;
            pend_q      <= pend_d;
            bin_out_q   <= bin_out_d;
            valid_q     <= valid_d;
            step_up_q   <= step_up_d;
            step_down_q <= step_down_d;
            jump_err_q  <= jump_err_d;
            err_count_q <= err_count_d;
        end
    end

    assign bin_out   = bin_out_q;
    assign valid     = valid_q;
    assign step_up   = step_up_q;
    assign step_down = step_down_q;
    assign jump_err  = jump_err_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_gray_decode_tracker.sv
// Self-checking bench for gray_decode_tracker: directed scenarios plus random traffic
// compared every cycle against a sample-level behavioural model.
module tb_gray_decode_tracker;
    import gray_dec_pkg::*;

    localparam int W    = GDT_WIDTH;
    localparam int LIM  = GDT_ERR_LIMIT;
    localparam int CW   = GDT_CNT_W;
    localparam int MASK = (1 << W) - 1;
    localparam int CMAX = (1 << CW) - 1;
`ifdef GRAY_DEC_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic          clk, rst;
    logic [W-1:0]  gray_in;
    logic          sample_en, err_clr;
    logic [W-1:0]  bin_out;
    logic          valid, step_up, step_down, jump_err;
    logic [CW-1:0] err_count;
    logic          fault;

    gray_decode_tracker #(.WIDTH(W), .ERR_LIMIT(LIM), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .gray_in   (gray_in),
        .sample_en (sample_en),
        .err_clr   (err_clr),
        .bin_out   (bin_out),
        .valid     (valid),
        .step_up   (step_up),
        .step_down (step_down),
        .jump_err  (jump_err),
        .err_count (err_count),
        .fault     (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] to_gray(input int b);
        return W'((b ^ (b >> 1)) & MASK);
    endfunction

    // Binary value of a gray word: XOR of the word with all its right shifts.
    function automatic int g2b(input int g);
        int b;
        b = g;
        for (int s = 1; s < W; s++) b = b ^ (g >> s);
        return b & MASK;
    endfunction

    // Behavioural model: one pending sample, previous position, fault/consec/count bookkeeping.
    bit m_pend, m_first, m_fault;
    int m_g, m_s1, m_s2, m_prev, m_consec, m_cnt;
    int e_bin, e_cnt;
    bit e_valid, e_up, e_dn, e_jmp;
    int mb, md, msrc;
    bit was_first;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pend = 0; m_first = 1; m_fault = 0;
            m_g = 0; m_s1 = 0; m_s2 = 0; m_prev = 0; m_consec = 0; m_cnt = 0;
            e_bin = 0; e_valid = 0; e_up = 0; e_dn = 0; e_jmp = 0;
        end else begin
            was_first = m_first;
            e_valid = 0; e_up = 0; e_dn = 0; e_jmp = 0;
            if (m_pend) begin
                mb = g2b(m_g);
                e_valid = 1;
                e_bin = mb;
                if (!m_first) begin
                    md = (mb - m_prev) & MASK;
                    if (md == 1) e_up = !m_fault;
                    else if (md == MASK) e_dn = !m_fault;
                    else if (md != 0) e_jmp = 1;
                    if (e_jmp) begin
                        if (m_cnt < CMAX) m_cnt++;
                        if (!m_fault) begin
                            m_consec++;
                            if (m_consec >= LIM) m_fault = 1;
                        end
                    end else if (!m_fault) begin
                        m_consec = 0;
                    end
                end
                m_prev = mb;
                m_first = 0;
            end
            if (err_clr) begin
                m_cnt = 0;
                if (!was_first) begin
                    m_fault = 0;
                    m_consec = 0;
                end
            end
`ifdef GRAY_DEC_SYNC_EN
            msrc = m_s2;
            m_s2 = m_s1;
            m_s1 = int'(gray_in);
`else
            msrc = int'(gray_in);
`endif
            m_pend = sample_en;
            if (sample_en) m_g = msrc;
        end
    end

    always @(negedge clk) begin
        e_cnt = m_cnt;
        check("bin_out",   32'(bin_out),   32'(e_bin));
        check("valid",     32'(valid),     32'(e_valid));
        check("step_up",   32'(step_up),   32'(e_up));
        check("step_down", 32'(step_down), 32'(e_dn));
        check("jump_err",  32'(jump_err),  32'(e_jmp));
        check("err_count", 32'(err_count), 32'(e_cnt));
        check("fault",     32'(fault),     32'(m_fault));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    // Present a binary position, capture it, and wait (bounded) for its valid pulse.
    task automatic do_sample(input int bval, output logic up, output logic dn,
                             output logic jmp, output int lat);
        gray_in = to_gray(bval);
        repeat (LAT - 2) tick();
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        lat = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            lat++;
            if (valid) break;
        end
        if (!valid) check("sample_timeout", 32'(valid), 32'd1);
        up = step_up; dn = step_down; jmp = jump_err;
    endtask

    logic u, d, j;
    int   lat;
    int   cur;

    initial begin
        rst = 1'b1; gray_in = '0; sample_en = 1'b0; err_clr = 1'b0;
        repeat (3) tick();
        check("rst_bin_out", 32'(bin_out), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        rst = 1'b0;
        tick();

        // Basic stepping from reset.
        do_sample(0, u, d, j, lat);
        check("t1_first_noflag", 32'({u, d, j}), 32'd0);
        check("t1_latency_sample", 32'(lat), 32'd2);
        check("t1_latency_gray", 32'(lat + LAT - 2), 32'(LAT));
        for (int v = 1; v <= 3; v++) begin
            do_sample(v, u, d, j, lat);
            check("t1_step_up", 32'({u, d, j}), 32'b100);
        end
        check("t1_bin_out", 32'(bin_out), 32'd3);

        // Wrap-around in both directions.
        do_sample(8'hFF, u, d, j, lat);
        check("t2_jump_to_ff", 32'(j), 32'd1);
        do_sample(8'h00, u, d, j, lat);
        check("t2_wrap_up", 32'({u, d, j}), 32'b100);
        do_sample(8'hFF, u, d, j, lat);
        check("t2_wrap_down", 32'({u, d, j}), 32'b010);

        // Single jump, then a clean step.
        do_sample(8'h10, u, d, j, lat);
        pulse_clr();
        do_sample(8'h14, u, d, j, lat);
        check("t3_jump", 32'(j), 32'd1);
        check("t3_err_count", 32'(err_count), 32'd1);
        check("t3_no_fault", 32'(fault), 32'd0);
        do_sample(8'h15, u, d, j, lat);
        check("t3_step_up", 32'({u, d, j}), 32'b100);

        // Consecutive jumps into FAULT, suppressed steps, and recovery.
        do_sample(8'h00, u, d, j, lat);
        pulse_clr();
        do_sample(8'h05, u, d, j, lat);
        do_sample(8'h0A, u, d, j, lat);
        check("t4_fault_before_limit", 32'(fault), 32'd0);
        do_sample(8'h0F, u, d, j, lat);
        check("t4_fault", 32'(fault), 32'd1);
        check("t4_err_count", 32'(err_count), 32'd3);
        do_sample(8'h10, u, d, j, lat);
        check("t4_step_suppressed", 32'({u, d, j}), 32'b000);
        check("t4_bin_in_fault", 32'(bin_out), 32'h10);
        pulse_clr();
        check("t4_clr_fault", 32'(fault), 32'd0);
        check("t4_clr_count", 32'(err_count), 32'd0);

        // err_clr at the same edge that registers a jump.
        gray_in = to_gray(8'h40);
        repeat (LAT - 2) tick();
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t5_jump_pulse", 32'({valid, jump_err}), 32'b11);
        check("t5_count_cleared", 32'(err_count), 32'd0);
        check("t5_no_fault", 32'(fault), 32'd0);
        do_sample(8'h41, u, d, j, lat);
        check("t5_track_step", 32'(u), 32'd1);

        // Saturation of the error counter.
        sample_en = 1'b1;
        for (int i = 0; i < 300 + LAT; i++) begin
            gray_in = (i % 2 == 1) ? to_gray(8'h80) : to_gray(8'h00);
            tick();
        end
        sample_en = 1'b0;
        repeat (LAT) tick();
        check("t5_saturate", 32'(err_count), 32'd255);
        check("t5_sat_fault", 32'(fault), 32'd1);

        // Asynchronous reset between edges.
        sample_en = 1'b1;
        gray_in = to_gray(8'h5A);
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        check("t6_rst_outputs", 32'({bin_out, valid, step_up, step_down, jump_err, fault}), 32'd0);
        check("t6_rst_count", 32'(err_count), 32'd0);
        rst = 1'b0;
        sample_en = 1'b0;
        tick();
        do_sample(8'h33, u, d, j, lat);
        check("t6_first_after_rst", 32'({u, d, j}), 32'd0);
        check("t6_bin_after_rst", 32'(bin_out), 32'h33);

        // Random traffic: mostly small moves, some jumps, sparse clears and resets.
        cur = 8'h33;
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: cur = (cur + 1) & MASK;
                4, 5, 6:    cur = (cur - 1) & MASK;
                7:          cur = cur;
                default:    cur = int'($urandom_range(0, MASK));
            endcase
            gray_in   = to_gray(cur);
            sample_en = ($urandom_range(0, 3) != 0);
            err_clr   = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 499) == 0) begin
                #2 rst = 1'b1;
                #1 rst = 1'b0;
            end
            tick();
        end
        sample_en = 1'b0;
        err_clr = 1'b0;
        repeat (LAT + 2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
